// File: rtl/write_bus_arbiter_pkg.sv
// Shared types and field widths for the write bus arbiter and its order FIFO.
package write_bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_e;

  localparam int unsigned BID_MSB   = 3;
  localparam int unsigned BID_LSB   = 2;
  localparam int unsigned AW_ID_W   = 4;
  localparam int unsigned AW_ADDR_W = 32;
  localparam int unsigned AW_ATOP_W = 6;
  localparam int unsigned W_DATA_W  = 32;

  // Index width for n items; never zero so single-master builds still elaborate.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wr_order_fifo.sv
// Order FIFO holding the master index of each accepted AW until its W burst completes.
module wr_order_fifo
  import write_bus_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_q];
  // A push while full is legal when the same cycle pops a slot free.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = (32'(wr_q) == DEPTH - 1) ? '0 : wr_q + PTR_W'(1);
    if (do_pop)  rd_d = (32'(rd_q) == DEPTH - 1) ? '0 : rd_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/write_bus_arbiter.sv
// Round-robin arbiter sharing one AXI-style write slave between NUM_M managers;
// W beats follow AW acceptance order, B responses route back by bid[3:2].
module write_bus_arbiter
  import write_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_M     = 4,
  parameter int unsigned ORD_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_M-1:0]             req_rq,
  output logic [NUM_M-1:0]             gnt_rq,
  input  logic [NUM_M-1:0]             m_awvalid,
  output logic [NUM_M-1:0]             m_awready,
  input  logic [AW_ID_W*NUM_M-1:0]     m_awid,
  input  logic [AW_ADDR_W*NUM_M-1:0]   m_awaddr,
  input  logic [AW_ATOP_W*NUM_M-1:0]   m_awatop,
  output logic                         s_awvalid,
  input  logic                         s_awready,
  output logic [AW_ID_W-1:0]           s_awid,
  output logic [AW_ADDR_W-1:0]         s_awaddr,
  output logic [AW_ATOP_W-1:0]         s_awatop,
  input  logic [NUM_M-1:0]             m_wvalid,
  output logic [NUM_M-1:0]             m_wready,
  input  logic [W_DATA_W*NUM_M-1:0]    m_wdata,
  input  logic [NUM_M-1:0]             m_wlast,
  output logic                         s_wvalid,
  input  logic                         s_wready,
  output logic [W_DATA_W-1:0]          s_wdata,
  output logic                         s_wlast,
  input  logic                         s_bvalid,
  output logic                         s_bready,
  input  logic [AW_ID_W-1:0]           s_bid,
  input  logic                         s_bcomp,
  output logic [NUM_M-1:0]             m_bvalid,
  input  logic [NUM_M-1:0]             m_bready,
  output logic [AW_ID_W-1:0]           m_bid,
  output logic                         m_bcomp
);

  localparam int unsigned IDX_W = idx_width(NUM_M);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gidx_q, gidx_d, rr_q, rr_d;
  logic [IDX_W-1:0] pick_idx, next_rr, head;
  logic             pick_vld, aw_hs;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign gnt_rq = gnt_q;

  always_comb begin : pick_blk
    int unsigned cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      cand = (32'(rr_q) + i) % NUM_M;
      if (!pick_vld && req_rq[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  assign next_rr = (32'(gidx_q) + 1 >= NUM_M) ? '0 : IDX_W'(32'(gidx_q) + 1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    fifo_push = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld && !fifo_full) begin
          state_d          = ST_GRANT;
          gnt_d            = '0;
          gnt_d[pick_idx]  = 1'b1;
          gidx_d           = pick_idx;
        end
      end
      ST_GRANT: begin
        if (aw_hs) begin
          fifo_push = 1'b1;
          gnt_d     = '0;
          rr_d      = next_rr;
          state_d   = ST_IDLE;
        end else if (!req_rq[gidx_q]) begin
          gnt_d   = '0;
          rr_d    = next_rr;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    s_awvalid = 1'b0;
    s_awid    = '0;
    s_awaddr  = '0;
    s_awatop  = '0;
    m_awready = '0;
    if (state_q == ST_GRANT) begin
      for (int unsigned i = 0; i < NUM_M; i++) begin
        if (32'(gidx_q) == i) begin
          s_awvalid    = m_awvalid[i];
          s_awid       = m_awid[i*AW_ID_W +: AW_ID_W];
          s_awaddr     = m_awaddr[i*AW_ADDR_W +: AW_ADDR_W];
          s_awatop     = m_awatop[i*AW_ATOP_W +: AW_ATOP_W];
          m_awready[i] = s_awready;
        end
      end
    end
  end

  assign aw_hs = s_awvalid && s_awready;

  wr_order_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (ORD_DEPTH)
  ) u_order_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (gidx_q),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Only the FIFO head's W channel is connected; everyone else stalls.
  always_comb begin
    s_wvalid = 1'b0;
    s_wdata  = '0;
    s_wlast  = 1'b0;
    m_wready = '0;
    if (!fifo_empty) begin
      for (int unsigned i = 0; i < NUM_M; i++) begin
        if (32'(head) == i) begin
          s_wvalid    = m_wvalid[i];
          s_wdata     = m_wdata[i*W_DATA_W +: W_DATA_W];
          s_wlast     = m_wlast[i];
          m_wready[i] = s_wready;
        end
      end
    end
  end

  assign fifo_pop = s_wvalid && s_wready && s_wlast;

  // Ids whose master field names no existing master are accepted and dropped.
  always_comb begin : b_route
    logic hit;
    hit      = 1'b0;
    m_bvalid = '0;
    s_bready = 1'b0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (32'(s_bid[BID_MSB:BID_LSB]) == i) begin
        m_bvalid[i] = s_bvalid;
        s_bready    = m_bready[i];
        hit         = 1'b1;
      end
    end
    if (!hit) s_bready = 1'b1;
  end

  assign m_bid   = s_bid;
  assign m_bcomp = s_bcomp;

endmodule

// File: tb/tb_write_bus_arbiter.sv
// Bench for write_bus_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_write_bus_arbiter;

  localparam int NM    = 4;
  localparam int DEPTH = 4;
  localparam int NTXN  = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM-1:0]   req_rq, gnt_rq, m_awvalid, m_awready;
  logic [4*NM-1:0] m_awid;
  logic [32*NM-1:0] m_awaddr;
  logic [6*NM-1:0] m_awatop;
  logic            s_awvalid, s_awready;
  logic [3:0]      s_awid;
  logic [31:0]     s_awaddr;
  logic [5:0]      s_awatop;
  logic [NM-1:0]   m_wvalid, m_wready, m_wlast;
  logic [32*NM-1:0] m_wdata;
  logic            s_wvalid, s_wready, s_wlast;
  logic [31:0]     s_wdata;
  logic            s_bvalid, s_bready, s_bcomp, m_bcomp;
  logic [3:0]      s_bid, m_bid;
  logic [NM-1:0]   m_bvalid, m_bready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  write_bus_arbiter #(.NUM_M(NM), .ORD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_rq(req_rq), .gnt_rq(gnt_rq),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awatop(m_awatop),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awatop(s_awatop),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bcomp(s_bcomp),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bcomp(m_bcomp)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    req_rq = '0; m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awatop = '0;
    s_awready = 1'b0; m_wvalid = '0; m_wdata = '0; m_wlast = '0; s_wready = 1'b0;
    s_bvalid = 1'b0; s_bid = '0; s_bcomp = 1'b0; m_bready = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic int len_of(input int m, input int j);
    return 1 + ((m + j) % 3);
  endfunction

  function automatic logic [31:0] enc(input int m, input int j, input int b);
    return {8'(m), 8'(j), 8'(b), 8'h5A};
  endfunction

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1; m_awvalid = '1; s_awready = 1'b1; m_wvalid = '1; m_wlast = '1; s_wready = 1'b1;
    tick(); tick(); settle();
    checks++; if (gnt_rq !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt_rq); end
    checks++; if (s_awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid got %b exp 0", s_awvalid); end
    checks++; if (s_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %b exp 0", s_wvalid); end
    checks++; if (m_awready !== 4'b0000) begin errors++; $display("FAIL reset_awready got %b exp 0000", m_awready); end
    checks++; if (m_wready !== 4'b0000) begin errors++; $display("FAIL reset_wready got %b exp 0000", m_wready); end
    checks++; if (m_bvalid !== 4'b0000) begin errors++; $display("FAIL reset_bvalid got %b exp 0000", m_bvalid); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single;
    do_reset();
    req_rq = 4'b0001; m_awvalid = 4'b0001; m_awaddr[31:0] = 32'h1000; m_awid[3:0] = 4'h3; s_awready = 1'b1;
    settle();
    checks++; if (gnt_rq !== 4'b0000) begin errors++; $display("FAIL single_gnt_early got %b exp 0000", gnt_rq); end
    tick(); settle();
    checks++; if (gnt_rq !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt_rq); end
    checks++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'h1000 || s_awid !== 4'h3)
      begin errors++; $display("FAIL single_aw got v=%b a=%h id=%h exp v=1 a=00001000 id=3", s_awvalid, s_awaddr, s_awid); end
    checks++; if (m_awready !== 4'b0001) begin errors++; $display("FAIL single_awready got %b exp 0001", m_awready); end
    tick();
    req_rq = '0; m_awvalid = '0;
    settle();
    checks++; if (gnt_rq !== 4'b0000) begin errors++; $display("FAIL single_gnt_drop got %b exp 0000", gnt_rq); end
    m_wvalid = 4'b0001; m_wdata[31:0] = 32'hD0; m_wlast = 4'b0001; s_wready = 1'b1;
    settle();
    checks++; if (s_wvalid !== 1'b1 || s_wdata !== 32'hD0 || m_wready !== 4'b0001)
      begin errors++; $display("FAIL single_w got v=%b d=%h rdy=%b exp v=1 d=000000d0 rdy=0001", s_wvalid, s_wdata, m_wready); end
    tick();
    m_wvalid = '0;
    settle();
    checks++; if (m_wready !== 4'b0000) begin errors++; $display("FAIL single_pop got %b exp 0000", m_wready); end
  endtask

  task automatic test_round_robin;
    int n, last, idx;
    do_reset();
    req_rq = '1; m_awvalid = '1; s_awready = 1'b1; m_wvalid = '1; m_wlast = '1; s_wready = 1'b1;
    for (int m = 0; m < NM; m++) m_awaddr[m*32 +: 32] = 32'h100 * m;
    n = 0; last = -10;
    for (int cyc = 0; cyc < 12; cyc++) begin
      settle();
      if (gnt_rq !== 4'b0000) begin
        idx = -1;
        for (int m = 0; m < NM; m++) if (gnt_rq[m]) idx = m;
        checks++; if (!$onehot(gnt_rq)) begin errors++; $display("FAIL rr_onehot got %b exp one-hot", gnt_rq); end
        if (n < 5) begin
          checks++; if (idx != n % NM) begin errors++; $display("FAIL rr_order grant %0d got m%0d exp m%0d", n, idx, n % NM); end
        end
        checks++; if (cyc - last < 2) begin errors++; $display("FAIL rr_spacing got %0d exp >=2", cyc - last); end
        last = cyc;
        n++;
      end
      tick();
    end
    checks++; if (n < 5) begin errors++; $display("FAIL rr_count got %0d exp >=5", n); end
  endtask

  task automatic test_w_order;
    do_reset();
    s_awready = 1'b1; s_wready = 1'b1;
    m_wvalid = 4'b0001; m_wdata[31:0] = 32'hA0;
    req_rq = 4'b0100; m_awvalid = 4'b0100; m_awaddr[95:64] = 32'h2000;
    settle();
    checks++; if (m_wready !== 4'b0000) begin errors++; $display("FAIL word_pre_aw got %b exp 0000", m_wready); end
    tick(); settle();
    checks++; if (gnt_rq !== 4'b0100) begin errors++; $display("FAIL word_gnt2 got %b exp 0100", gnt_rq); end
    tick();
    req_rq = 4'b0001; m_awvalid = 4'b0001; m_awaddr[31:0] = 32'h3000;
    settle();
    checks++; if (m_wready !== 4'b0100 || s_wvalid !== 1'b0)
      begin errors++; $display("FAIL word_head2 got rdy=%b v=%b exp rdy=0100 v=0", m_wready, s_wvalid); end
    tick(); settle();
    checks++; if (gnt_rq !== 4'b0001) begin errors++; $display("FAIL word_gnt0 got %b exp 0001", gnt_rq); end
    tick();
    req_rq = '0; m_awvalid = '0;
    for (int b = 0; b < 4; b++) begin
      m_wvalid = 4'b0101; m_wdata[95:64] = 32'hB0 + b; m_wlast = (b == 3) ? 4'b0100 : 4'b0000;
      settle();
      checks++; if (s_wvalid !== 1'b1 || s_wdata !== 32'hB0 + b || m_wready !== 4'b0100)
        begin errors++; $display("FAIL word_m2_beat%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0100", b, s_wvalid, s_wdata, m_wready, 32'hB0 + b); end
      tick();
    end
    m_wvalid = 4'b0001;
    for (int b = 0; b < 4; b++) begin
      m_wdata[31:0] = 32'hA0 + b; m_wlast = (b == 3) ? 4'b0001 : 4'b0000;
      settle();
      checks++; if (s_wdata !== 32'hA0 + b || m_wready !== 4'b0001 || s_wlast !== (b == 3))
        begin errors++; $display("FAIL word_m0_beat%0d got d=%h rdy=%b last=%b exp d=%h rdy=0001", b, s_wdata, m_wready, s_wlast, 32'hA0 + b); end
      tick();
    end
    m_wvalid = '0;
    settle();
    checks++; if (m_wready !== 4'b0000) begin errors++; $display("FAIL word_drained got %b exp 0000", m_wready); end
  endtask

  task automatic test_fifo_full;
    do_reset();
    s_awready = 1'b1;
    for (int m = 0; m < NM; m++) begin
      req_rq = 4'(1 << m); m_awvalid = 4'(1 << m);
      tick(); settle();
      checks++; if (gnt_rq !== 4'(1 << m)) begin errors++; $display("FAIL full_fill%0d got %b exp %b", m, gnt_rq, 4'(1 << m)); end
      tick();
      req_rq = '0; m_awvalid = '0;
    end
    req_rq = 4'b0001; m_awvalid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (gnt_rq !== 4'b0000) begin errors++; $display("FAIL full_block%0d got %b exp 0000", c, gnt_rq); end
      tick();
    end
    m_wvalid = 4'b0001; m_wlast = 4'b0001; s_wready = 1'b1;
    settle();
    checks++; if (m_wready !== 4'b0001) begin errors++; $display("FAIL full_head got %b exp 0001", m_wready); end
    tick();
    m_wvalid = '0; s_wready = 1'b0;
    settle();
    checks++; if (gnt_rq !== 4'b0000) begin errors++; $display("FAIL full_pop_edge got %b exp 0000", gnt_rq); end
    tick(); settle();
    checks++; if (gnt_rq !== 4'b0001) begin errors++; $display("FAIL full_after_pop got %b exp 0001", gnt_rq); end
  endtask

  task automatic test_b_route;
    int k;
    logic [3:0] eb;
    clear_inputs();
    s_bid = 4'b1001; s_bvalid = 1'b1; m_bready = 4'b1011; s_bcomp = 1'b1;
    settle();
    checks++; if (m_bvalid !== 4'b0100 || s_bready !== 1'b0)
      begin errors++; $display("FAIL b_stall got bv=%b br=%b exp bv=0100 br=0", m_bvalid, s_bready); end
    checks++; if (m_bid !== 4'b1001 || m_bcomp !== 1'b1)
      begin errors++; $display("FAIL b_fields got id=%b comp=%b exp id=1001 comp=1", m_bid, m_bcomp); end
    m_bready = 4'b1111;
    settle();
    checks++; if (s_bready !== 1'b1) begin errors++; $display("FAIL b_ready got %b exp 1", s_bready); end
    for (int r = 0; r < 16; r++) begin
      s_bid = 4'($urandom); s_bvalid = 1'($urandom); m_bready = 4'($urandom); s_bcomp = 1'($urandom);
      settle();
      k = s_bid / 4;
      eb = s_bvalid ? 4'(1 << k) : 4'b0000;
      checks++; if (m_bvalid !== eb || s_bready !== m_bready[k] || m_bid !== s_bid || m_bcomp !== s_bcomp)
        begin errors++; $display("FAIL b_rand%0d got bv=%b br=%b id=%b exp bv=%b br=%b id=%b", r, m_bvalid, s_bready, m_bid, eb, m_bready[k], s_bid); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    s_awready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req_rq = 4'(1 << m); m_awvalid = 4'(1 << m);
      tick(); tick();
      req_rq = '0; m_awvalid = '0;
    end
    req_rq = 4'b0100;
    tick();
    m_wvalid = 4'b0001;
    settle();
    checks++; if (gnt_rq !== 4'b0100 || s_wvalid !== 1'b1)
      begin errors++; $display("FAIL rstmid_pre got gnt=%b wv=%b exp gnt=0100 wv=1", gnt_rq, s_wvalid); end
    rst = 1'b1;
    tick();
    rst = 1'b0; s_wready = 1'b1;
    settle();
    checks++; if (gnt_rq !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt got %b exp 0000", gnt_rq); end
    checks++; if (s_wvalid !== 1'b0 || m_wready !== 4'b0000)
      begin errors++; $display("FAIL rstmid_fifo got wv=%b rdy=%b exp wv=0 rdy=0000", s_wvalid, m_wready); end
    req_rq = 4'b1111;
    tick(); settle();
    checks++; if (gnt_rq !== 4'b0001) begin errors++; $display("FAIL rstmid_rr got %b exp 0001", gnt_rq); end
  endtask

  typedef struct {
    int m;
    int txn;
  } ord_t;

  task automatic test_random;
    ord_t q[$];
    int aw_sent[NM], w_txn[NM], w_beat[NM];
    int exp_g, rr, qbeat, h, c;
    bit full_now, aw_hs, done;
    logic [3:0] eg;
    do_reset();
    for (int m = 0; m < NM; m++) begin aw_sent[m] = 0; w_txn[m] = 0; w_beat[m] = 0; end
    exp_g = -1; rr = 0; qbeat = 0; done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      for (int m = 0; m < NM; m++) begin
        req_rq[m]          = aw_sent[m] < NTXN;
        m_awvalid[m]       = req_rq[m] && ($urandom_range(3) != 0);
        m_awaddr[m*32 +: 32] = {16'(m), 16'(aw_sent[m])};
        m_awid[m*4 +: 4]   = {2'(m), 2'(aw_sent[m])};
        m_wvalid[m]        = (w_txn[m] < NTXN) && ($urandom_range(3) != 0);
        m_wdata[m*32 +: 32] = enc(m, w_txn[m], w_beat[m]);
        m_wlast[m]         = (w_beat[m] == len_of(m, w_txn[m]) - 1);
      end
      s_awready = 1'($urandom_range(1));
      s_wready  = ($urandom_range(2) != 0);
      settle();
      eg = (exp_g < 0) ? 4'b0000 : 4'(1 << exp_g);
      checks++; if (gnt_rq !== eg) begin errors++; $display("FAIL rand_gnt cyc%0d got %b exp %b", cyc, gnt_rq, eg); end
      if (exp_g >= 0) begin
        checks++; if (s_awvalid !== m_awvalid[exp_g] || m_awready !== (s_awready ? eg : 4'b0000))
          begin errors++; $display("FAIL rand_aw cyc%0d got v=%b rdy=%b exp v=%b", cyc, s_awvalid, m_awready, m_awvalid[exp_g]); end
        if (m_awvalid[exp_g]) begin
          checks++; if (s_awaddr !== {16'(exp_g), 16'(aw_sent[exp_g])} || s_awid !== {2'(exp_g), 2'(aw_sent[exp_g])})
            begin errors++; $display("FAIL rand_awaddr cyc%0d got %h exp %h", cyc, s_awaddr, {16'(exp_g), 16'(aw_sent[exp_g])}); end
        end
      end
      h = (q.size() > 0) ? q[0].m : -1;
      if (h < 0) begin
        checks++; if (s_wvalid !== 1'b0 || m_wready !== 4'b0000)
          begin errors++; $display("FAIL rand_wempty cyc%0d got v=%b rdy=%b exp v=0 rdy=0000", cyc, s_wvalid, m_wready); end
      end else begin
        checks++; if (s_wvalid !== m_wvalid[h] || m_wready !== (s_wready ? 4'(1 << h) : 4'b0000))
          begin errors++; $display("FAIL rand_wsel cyc%0d got v=%b rdy=%b exp head m%0d", cyc, s_wvalid, m_wready, h); end
        if (m_wvalid[h]) begin
          checks++; if (s_wdata !== enc(h, q[0].txn, qbeat) || s_wlast !== (qbeat == len_of(h, q[0].txn) - 1))
            begin errors++; $display("FAIL rand_wdata cyc%0d got %h exp %h", cyc, s_wdata, enc(h, q[0].txn, qbeat)); end
        end
      end
      full_now = (q.size() == DEPTH);
      aw_hs    = (exp_g >= 0) && m_awvalid[exp_g] && s_awready;
      if (h >= 0 && m_wvalid[h] && s_wready) begin
        w_beat[h]++; qbeat++;
        if (qbeat == len_of(h, q[0].txn)) begin
          void'(q.pop_front());
          qbeat = 0; w_txn[h]++; w_beat[h] = 0;
        end
      end
      if (exp_g >= 0) begin
        if (aw_hs) begin
          q.push_back('{m: exp_g, txn: aw_sent[exp_g]});
          aw_sent[exp_g]++;
          rr = (exp_g + 1) % NM; exp_g = -1;
        end else if (!req_rq[exp_g]) begin
          rr = (exp_g + 1) % NM; exp_g = -1;
        end
      end else if (req_rq != 0 && !full_now) begin
        for (int i = 0; i < NM; i++) begin
          c = (rr + i) % NM;
          if (exp_g < 0 && req_rq[c]) exp_g = c;
        end
      end
      tick();
      done = 1'b1;
      for (int m = 0; m < NM; m++) if (w_txn[m] < NTXN) done = 1'b0;
    end
    checks++; if (!done) begin errors++; $display("FAIL rand_complete got incomplete exp all %0d bursts per master", NTXN); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_w_order();
    test_fifo_full();
    test_b_route();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
